// File: rtl/chaser_pkg.sv
// Shared state encoding and direction constants for the LED chaser.
package chaser_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MOVE_UP = 2'd1,
    MOVE_DN = 2'd2
  } chaser_state_e;

  localparam logic DIR_UP = 1'b0;
  localparam logic DIR_DN = 1'b1;

endpackage

// File: rtl/tick_led_chaser_rise_detect.sv
// Registered-previous rising-edge detector used for the reverse key.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (reset) d_q <= 1'b0;
    else       d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/tick_led_chaser.sv
// Bouncing single-LED chaser stepped by divider ticks.
// Optional tick prescaler enabled by defining CHASER_TICK_DIV_EN.
module tick_led_chaser
  import chaser_pkg::*;
#(
  parameter int N        = 8,
  parameter int PW       = $clog2(N),
  parameter int TICK_DIV = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          run,
  input  logic          rev_key,
  output logic [N-1:0]  leds,
  output logic [PW-1:0] pos,
  output logic          dir,
  output logic          lap
);

  localparam logic [PW-1:0] LAST = PW'(N - 1);

  chaser_state_e state, state_n;
  logic [PW-1:0] pos_n;
  logic [N-1:0]  leds_n;
  logic          dir_n, lap_n;
  logic          rev_pend, rev_pend_n;
  logic          rise, rev_eff, adv;

  rise_detect u_rev_edge (
    .clk   (clk),
    .reset (reset),
    .d     (rev_key),
    .rise  (rise)
  );

`ifdef CHASER_TICK_DIV_EN
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [CW-1:0] pre_cnt;

  // Only ticks that arrive while running advance the prescaler.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (tick && run) begin
      if (pre_cnt == CW'(TICK_DIV - 1)) pre_cnt <= '0;
      else                               pre_cnt <= pre_cnt + CW'(1);
    end
  end

  assign adv = tick & run & (pre_cnt == CW'(TICK_DIV - 1));
`else
  localparam int tick_div_unused = TICK_DIV;
  assign adv = tick & run;
`endif

  // An edge arriving in the same cycle as a step reverses that very step.
  assign rev_eff = rev_pend | rise;

  always_comb begin
    state_n    = state;
    pos_n      = pos;
    dir_n      = dir;
    lap_n      = 1'b0;
    rev_pend_n = rev_pend | rise;
    if (adv) begin
      rev_pend_n = 1'b0;
      case (state)
        IDLE: begin
          state_n = MOVE_UP;
          pos_n   = '0;
          dir_n   = DIR_UP;
        end
        MOVE_UP: begin
          if (rev_eff) begin
            state_n = MOVE_DN;
            dir_n   = DIR_DN;
            if (pos != '0) pos_n = pos - PW'(1);
          end else if (pos == LAST) begin
            state_n = MOVE_DN;
            dir_n   = DIR_DN;
            pos_n   = LAST - PW'(1);
            lap_n   = 1'b1;
          end else begin
            pos_n = pos + PW'(1);
          end
        end
        default: begin
          if (rev_eff) begin
            state_n = MOVE_UP;
            dir_n   = DIR_UP;
            if (pos != LAST) pos_n = pos + PW'(1);
          end else if (pos == '0) begin
            state_n = MOVE_UP;
            dir_n   = DIR_UP;
            pos_n   = PW'(1);
            lap_n   = 1'b1;
          end else begin
            pos_n = pos - PW'(1);
          end
        end
      endcase
    end
    leds_n = '0;
    if (state_n != IDLE) leds_n[pos_n] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pos      <= '0;
      dir      <= DIR_UP;
      lap      <= 1'b0;
      leds     <= '0;
      rev_pend <= 1'b0;
    end else begin
      state    <= state_n;
      pos      <= pos_n;
      dir      <= dir_n;
      lap      <= lap_n;
      leds     <= leds_n;
      rev_pend <= rev_pend_n;
    end
  end

endmodule

// File: tb/tb_tick_led_chaser.sv
// Self-checking bench for tick_led_chaser: per-cycle behavioural model plus literal spot checks.
module tb_tick_led_chaser;

  localparam int N        = 8;
  localparam int PW       = $clog2(N);
  localparam int TICK_DIV = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          tick = 1'b0;
  logic          run = 1'b0;
  logic          revKey = 1'b0;
  logic [N-1:0]  leds;
  logic [PW-1:0] pos;
  logic          dir;
  logic          lap;

  int numChecks = 0;
  int numFails  = 0;
  bit checkEn   = 1'b0;

  // Model state: position as an integer, step as +1/-1.
  int mPos = 0;
  int mStep = 1;
  int mCnt = 0;
  bit mActive = 1'b0;
  bit mLap = 1'b0;
  bit mPend = 1'b0;
  bit prevKey = 1'b0;
  bit edgeNow, advNow;
  logic [N-1:0] expLeds;

  tick_led_chaser #(.N(N), .TICK_DIV(TICK_DIV)) dut (
    .clk     (clk),
    .reset   (reset),
    .tick    (tick),
    .run     (run),
    .rev_key (revKey),
    .leds    (leds),
    .pos     (pos),
    .dir     (dir),
    .lap     (lap)
  );

  always #5 clk = ~clk;

  // Behavioural model evaluated on the same edge the DUT registers on.
  always @(posedge clk) begin
    if (reset) begin
      mActive = 1'b0; mPos = 0; mStep = 1; mLap = 1'b0;
      mPend = 1'b0; prevKey = 1'b0; mCnt = 0;
    end else begin
      edgeNow = revKey && !prevKey;
      prevKey = revKey;
`ifdef CHASER_TICK_DIV_EN
      advNow = 1'b0;
      if (tick && run) begin
        if (mCnt == TICK_DIV - 1) begin
          advNow = 1'b1;
          mCnt = 0;
        end else begin
          mCnt++;
        end
      end
`else
      advNow = tick && run;
`endif
      mLap = 1'b0;
      if (advNow) begin
        if (!mActive) begin
          mActive = 1'b1; mPos = 0; mStep = 1;
        end else if (mPend || edgeNow) begin
          mStep = -mStep;
          if (mPos + mStep >= 0 && mPos + mStep <= N - 1) mPos = mPos + mStep;
        end else if (mPos + mStep < 0 || mPos + mStep > N - 1) begin
          mStep = -mStep;
          mPos = mPos + mStep;
          mLap = 1'b1;
        end else begin
          mPos = mPos + mStep;
        end
        mPend = 1'b0;
      end else begin
        mPend = mPend || edgeNow;
      end
    end
  end

  task automatic checkField(input string name, input int actual, input int expected);
    numChecks++;
    if (actual != expected) begin
      numFails++;
      $display("[TB] FAIL %s at %0t: got %0d expected %0d", name, $time, actual, expected);
    end
  endtask

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (checkEn) begin
      expLeds = mActive ? (N'(1) << mPos) : '0;
      checkField("model.pos",  int'(pos),  mPos);
      checkField("model.dir",  int'(dir),  (mStep < 0) ? 1 : 0);
      checkField("model.lap",  int'(lap),  int'(mLap));
      checkField("model.leds", int'(leds), int'(expLeds));
    end
  end

  task automatic applyStimulus(input logic t, input logic r, input logic k, input logic rs);
    tick = t; run = r; revKey = k; reset = rs;
    @(negedge clk);
  endtask

  task automatic checkOutput(input string name, input int ePos, input int eDir,
                             input int eLap, input int eLeds);
    checkField({name, ".pos"},  int'(pos),  ePos);
    checkField({name, ".dir"},  int'(dir),  eDir);
    checkField({name, ".lap"},  int'(lap),  eLap);
    checkField({name, ".leds"}, int'(leds), eLeds);
  endtask

  // One tick pulse followed by a quiet cycle; outputs after the pulse reflect the step.
  task automatic pulseTick(input logic k);
    applyStimulus(1'b1, 1'b1, k, 1'b0);
  endtask

  task automatic quiet(input logic k);
    applyStimulus(1'b0, 1'b1, k, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkEn = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
    checkOutput("reset", 0, 0, 0, 0);
    quiet(1'b0);

    // Nine ticks: 0..7 then bounce to 6 with lap.
    for (int i = 0; i < 8; i++) begin pulseTick(1'b0); quiet(1'b0); end
`ifndef CHASER_TICK_DIV_EN
    checkOutput("sweepTop", 7, 0, 0, 8'h80);
`endif
    pulseTick(1'b0);
`ifndef CHASER_TICK_DIV_EN
    checkOutput("bounceTop", 6, 1, 1, 8'h40);
`endif
    quiet(1'b0);
`ifndef CHASER_TICK_DIV_EN
    checkOutput("lapOnce", 6, 1, 0, 8'h40);
`endif

    // Paused ticks are dropped, then one tick advances one step.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    end
`ifndef CHASER_TICK_DIV_EN
    checkOutput("pauseHold", 6, 1, 0, 8'h40);
`endif
    pulseTick(1'b0); quiet(1'b0);
`ifndef CHASER_TICK_DIV_EN
    checkOutput("resume", 5, 1, 0, 8'h20);
`endif

    // 5 -> 0, bounce to 1, then up to 3.
    for (int i = 0; i < 8; i++) begin pulseTick(1'b0); quiet(1'b0); end
`ifndef CHASER_TICK_DIV_EN
    checkOutput("atThreeUp", 3, 0, 0, 8'h08);
`endif

    // Held key gives one reversal only: 2,1,0 then bounce to 1.
    quiet(1'b1);
    for (int i = 0; i < 3; i++) begin pulseTick(1'b1); quiet(1'b1); end
`ifndef CHASER_TICK_DIV_EN
    checkOutput("heldKey", 0, 1, 0, 8'h01);
`endif
    pulseTick(1'b1);
`ifndef CHASER_TICK_DIV_EN
    checkOutput("bounceLow", 1, 0, 1, 8'h02);
`endif
    quiet(1'b0);

    // Up to 7, then key edge coincident with tick flips without lap.
    for (int i = 0; i < 6; i++) begin pulseTick(1'b0); quiet(1'b0); end
    pulseTick(1'b1);
`ifndef CHASER_TICK_DIV_EN
    checkOutput("edgeAtTop", 6, 1, 0, 8'h40);
`endif
    quiet(1'b1);
    quiet(1'b0);

    // Reset together with a tick at pos 5.
    pulseTick(1'b0); quiet(1'b0);
`ifndef CHASER_TICK_DIV_EN
    checkOutput("preReset", 5, 1, 0, 8'h20);
`endif
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1);
    checkOutput("midReset", 0, 0, 0, 0);
    quiet(1'b0);

    // Eight ticks from reset.
    for (int i = 0; i < 8; i++) begin pulseTick(1'b0); quiet(1'b0); end
`ifdef CHASER_TICK_DIV_EN
    checkOutput("eightTicks", 1, 0, 0, 8'h02);
`else
    checkOutput("eightTicks", 7, 0, 0, 8'h80);
`endif

    checkEn = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", numChecks, numFails);
    $finish;
  end

endmodule
